// File: rtl/norm_pipe.sv
// ============================================================================
// Module      : norm_pipe
// Description : Two-stage normaliser for a floating-point adder result.
//               Stage 1 registers the raw sum and its leading-zero count;
//               stage 2 shifts the mantissa, adjusts the exponent and
//               raises the zero / underflow / exponent-saturation flags.
//               Valid/ready handshake on both sides, one beat per cycle.
// Options     : NORM_PIPE_STICKY_EN - when defined, the bit shifted out on
//               a carry-out is ORed into the result LSB as a sticky bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module norm_pipe #(
   parameter int SIZE_DATA = 16,
   parameter int SIZE_EXP  = 8,
   parameter int SIZE_LOPD = $clog2(SIZE_DATA)
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic                 i_overflow,
   input  logic [SIZE_DATA-1:0] i_mantissa,
   input  logic [SIZE_EXP-1:0]  i_exponent,
   output logic                 o_valid,
   input  logic                 i_ready,
   output logic [SIZE_DATA-1:0] o_mantissa,
   output logic [SIZE_EXP-1:0]  o_exponent,
   output logic                 o_zero,
   output logic                 o_underflow,
   output logic                 o_exp_sat
);

   // Comparison width wide enough for both the shift count and the exponent
   localparam int C_CMP_W = ((SIZE_LOPD > SIZE_EXP) ? SIZE_LOPD : SIZE_EXP) + 1;

   // Stage 1 registers
   logic                 r_s1_valid;
   logic                 r_s1_ovf;
   logic                 r_s1_zero;
   logic [SIZE_DATA-1:0] r_s1_mant;
   logic [SIZE_EXP-1:0]  r_s1_exp;
   logic [SIZE_LOPD-1:0] r_s1_lz;

   // Stage 2 registers (drive the outputs directly)
   logic                 r_s2_valid;
   logic [SIZE_DATA-1:0] r_mant;
   logic [SIZE_EXP-1:0]  r_exp;
   logic                 r_zero;
   logic                 r_uf;
   logic                 r_sat;

   // Handshake and stage-1 combinational results
   logic                 w_s2_adv;
   logic                 w_in_xfer;
   logic [SIZE_LOPD-1:0] w_lz;
   logic                 w_zero;

   // Stage-2 next-state values
   logic [SIZE_DATA-1:0] w_nx_mant;
   logic [SIZE_EXP-1:0]  w_nx_exp;
   logic                 w_nx_zero;
   logic                 w_nx_uf;
   logic                 w_nx_sat;
   logic [C_CMP_W-1:0]   w_lz_ext;
   logic [C_CMP_W-1:0]   w_exp_ext;

   // Stage 2 can take new content when empty or when its beat leaves now.
   // Stage 1 frees up whenever stage 2 can take its beat.
   assign w_s2_adv  = ~r_s2_valid | i_ready;
   assign o_ready   = ~r_s1_valid | w_s2_adv;
   assign w_in_xfer = i_valid & o_ready;

   // A true zero only exists without a carry-out; a carry makes the sum nonzero
   assign w_zero = ~i_overflow & (i_mantissa == '0);

   // Leading-zero count: the highest set bit wins, scanned from the LSB upward
   always_comb begin
      w_lz = '0;
      for (int i = 0; i < SIZE_DATA; i++) begin
         if (i_mantissa[i]) begin
            w_lz = SIZE_LOPD'(SIZE_DATA - 1 - i);
         end
      end
   end

   assign w_lz_ext  = C_CMP_W'(r_s1_lz);
   assign w_exp_ext = C_CMP_W'(r_s1_exp);

   // Normalisation of the stage-1 beat; all fields are zero for an empty stage
   always_comb begin
      w_nx_mant = '0;
      w_nx_exp  = '0;
      w_nx_zero = 1'b0;
      w_nx_uf   = 1'b0;
      w_nx_sat  = 1'b0;
      if (r_s1_valid) begin
         if (r_s1_zero) begin
            w_nx_zero = 1'b1;
         end else if (r_s1_ovf) begin
            w_nx_mant = {1'b1, r_s1_mant[SIZE_DATA-1:1]};
`ifdef NORM_PIPE_STICKY_EN
            w_nx_mant[0] = r_s1_mant[1] | r_s1_mant[0];
`endif
            if (r_s1_exp == '1) begin
               w_nx_exp = '1;
               w_nx_sat = 1'b1;
            end else begin
               w_nx_exp = r_s1_exp + SIZE_EXP'(1);
            end
         end else if (r_s1_lz == '0) begin
            // Already normalised
            w_nx_mant = r_s1_mant;
            w_nx_exp  = r_s1_exp;
         end else if (w_lz_ext < w_exp_ext) begin
            // lz < exponent guarantees lz fits in SIZE_EXP bits
            w_nx_mant = r_s1_mant << r_s1_lz;
            w_nx_exp  = r_s1_exp - SIZE_EXP'(r_s1_lz);
         end else begin
            // Exponent would drop below 1: flush to zero
            w_nx_zero = 1'b1;
            w_nx_uf   = 1'b1;
         end
      end
   end

   // Stage 1: capture inputs, leading-zero count and zero detect
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s1_valid <= 1'b0;
         r_s1_ovf   <= 1'b0;
         r_s1_zero  <= 1'b0;
         r_s1_mant  <= '0;
         r_s1_exp   <= '0;
         r_s1_lz    <= '0;
      end else if (w_in_xfer) begin
         r_s1_valid <= 1'b1;
         r_s1_ovf   <= i_overflow;
         r_s1_zero  <= w_zero;
         r_s1_mant  <= i_mantissa;
         r_s1_exp   <= i_exponent;
         r_s1_lz    <= w_lz;
      end else if (w_s2_adv) begin
         r_s1_valid <= 1'b0;
      end
   end

   // Stage 2: register the normalised result; holds while stalled downstream
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_s2_valid <= 1'b0;
         r_mant     <= '0;
         r_exp      <= '0;
         r_zero     <= 1'b0;
         r_uf       <= 1'b0;
         r_sat      <= 1'b0;
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         r_mant     <= w_nx_mant;
         r_exp      <= w_nx_exp;
         r_zero     <= w_nx_zero;
         r_uf       <= w_nx_uf;
         r_sat      <= w_nx_sat;
      end
   end

   assign o_valid     = r_s2_valid;
   assign o_mantissa  = r_mant;
   assign o_exponent  = r_exp;
   assign o_zero      = r_zero;
   assign o_underflow = r_uf;
   assign o_exp_sat   = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_norm_pipe.sv
// ============================================================================
// Module      : tb_norm_pipe
// Description : Self-checking bench for norm_pipe (SIZE_DATA=16, SIZE_EXP=8).
//               Directed vector table, backpressure and reset sequences,
//               then randomized traffic against a scoreboard model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_norm_pipe;

   logic        clk;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic        i_overflow;
   logic [15:0] i_mantissa;
   logic [7:0]  i_exponent;
   logic        o_valid;
   logic        i_ready;
   logic [15:0] o_mantissa;
   logic [7:0]  o_exponent;
   logic        o_zero;
   logic        o_underflow;
   logic        o_exp_sat;

   norm_pipe #(
      .SIZE_DATA (16),
      .SIZE_EXP  (8)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_overflow  (i_overflow),
      .i_mantissa  (i_mantissa),
      .i_exponent  (i_exponent),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_mantissa  (o_mantissa),
      .o_exponent  (o_exponent),
      .o_zero      (o_zero),
      .o_underflow (o_underflow),
      .o_exp_sat   (o_exp_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef NORM_PIPE_STICKY_EN
   localparam logic [15:0] C_OVF_MANT = 16'h8003;
   localparam bit          C_STICKY   = 1'b1;
`else
   localparam logic [15:0] C_OVF_MANT = 16'h8002;
   localparam bit          C_STICKY   = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] m;
      logic [7:0]  e;
      logic        z;
      logic        u;
      logic        s;
   } res_t;

   typedef struct {
      string       name;
      logic        ovf;
      logic [15:0] mant;
      logic [7:0]  exp;
      res_t        res;
   } vec_t;

   int   n_total = 0;
   int   n_pass  = 0;
   int   out_cnt = 0;
   res_t sb_q[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h", nm, act, req);
   endtask

   // Reference: normalisation from the arithmetic rules of the format
   function automatic res_t model(input logic ovf, input logic [15:0] m, input logic [7:0] e);
      res_t r;
      int   lz;
      logic [15:0] t;
      r = '0;
      if (!ovf && m == 0) begin
         r.z = 1'b1;
      end else if (ovf) begin
         r.m = (m >> 1) | 16'h8000;
         if (C_STICKY && m[0]) r.m = r.m | 16'h0001;
         if (e == 8'd255) begin
            r.e = 8'd255;
            r.s = 1'b1;
         end else begin
            r.e = e + 8'd1;
         end
      end else begin
         lz = 0;
         t  = m;
         while (t[15] == 1'b0) begin
            t = t << 1;
            lz++;
         end
         if (lz == 0) begin
            r.m = m;
            r.e = e;
         end else if (lz < int'(e)) begin
            r.m = t;
            r.e = 8'(int'(e) - lz);
         end else begin
            r.z = 1'b1;
            r.u = 1'b1;
         end
      end
      return r;
   endfunction

   // Monitor: scoreboard, idle-flag and stall-stability checks each cycle
   logic prev_hold = 1'b0;
   res_t prev_out;
   always @(negedge clk) begin
      res_t cur;
      cur = {o_mantissa, o_exponent, o_zero, o_underflow, o_exp_sat};
      if (i_rst) begin
         sb_q.delete();
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("stall_stable", {o_valid, cur}, {1'b1, prev_out});
         end
         if (!o_valid) begin
            chk("idle_flags", {o_zero, o_underflow, o_exp_sat}, 3'b000);
         end
         if (o_valid && i_ready) begin
            out_cnt++;
            if (sb_q.size() == 0) chk("unexpected_out", 1, 0);
            else chk("out_beat", cur, sb_q.pop_front());
         end
         if (i_valid && o_ready) begin
            sb_q.push_back(model(i_overflow, i_mantissa, i_exponent));
         end
         prev_hold = o_valid & ~i_ready;
         prev_out  = cur;
      end
   end

   // Present one beat (called just after a rising edge); returns just after
   // the edge on which it transferred
   task automatic send_beat(input logic ovf, input logic [15:0] m, input logic [7:0] e);
      int n;
      i_valid    = 1'b1;
      i_overflow = ovf;
      i_mantissa = m;
      i_exponent = e;
      n = 0;
      @(negedge clk);
      while (!o_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) chk("send_timeout", 0, 1);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
   endtask

   // One beat through an idle pipe: exact 2-cycle latency and result fields
   task automatic run_vec(input vec_t v);
      send_beat(v.ovf, v.mant, v.exp);
      @(negedge clk);
      chk({v.name, "_lat1"}, o_valid, 1'b0);
      @(negedge clk);
      chk({v.name, "_valid"}, o_valid, 1'b1);
      chk({v.name, "_mant"}, o_mantissa, v.res.m);
      chk({v.name, "_exp"}, o_exponent, v.res.e);
      chk({v.name, "_flags"}, {o_zero, o_underflow, o_exp_sat}, {v.res.z, v.res.u, v.res.s});
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      int n;
      i_valid = 1'b0;
      i_ready = 1'b1;
      n = 0;
      while ((sb_q.size() != 0 || o_valid) && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(nm, sb_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   vec_t vecs[10];

   initial begin
      int   base;
      res_t hold_val;

      vecs[0] = '{"norm_shift", 1'b0, 16'h0100,   8'd20, '{16'h8000, 8'd13,  1'b0, 1'b0, 1'b0}};
      vecs[1] = '{"ovf_basic",  1'b1, 16'h0005,   8'd10, '{C_OVF_MANT, 8'd11, 1'b0, 1'b0, 1'b0}};
      vecs[2] = '{"underflow",  1'b0, 16'h0001,   8'd5,  '{16'h0000, 8'd0,   1'b1, 1'b1, 1'b0}};
      vecs[3] = '{"zero",       1'b0, 16'h0000,   8'd77, '{16'h0000, 8'd0,   1'b1, 1'b0, 1'b0}};
      vecs[4] = '{"ovf_fe",     1'b1, 16'hF00F,   8'hFE, '{16'hF807, 8'hFF,  1'b0, 1'b0, 1'b0}};
      vecs[5] = '{"ovf_ff_sat", 1'b1, 16'h1234,   8'hFF, '{16'h891A, 8'hFF,  1'b0, 1'b0, 1'b1}};
      vecs[6] = '{"msb_pass",   1'b0, 16'hA5A5,   8'd0,  '{16'hA5A5, 8'd0,   1'b0, 1'b0, 1'b0}};
      vecs[7] = '{"lz_eq_exp",  1'b0, 16'h0800,   8'd4,  '{16'h0000, 8'd0,   1'b1, 1'b1, 1'b0}};
      vecs[8] = '{"lz_lt_exp",  1'b0, 16'h0800,   8'd5,  '{16'h8000, 8'd1,   1'b0, 1'b0, 1'b0}};
      vecs[9] = '{"ovf_zero_m", 1'b1, 16'h0000,   8'd3,  '{16'h8000, 8'd4,   1'b0, 1'b0, 1'b0}};

      i_rst      = 1'b1;
      i_valid    = 1'b1;
      i_ready    = 1'b1;
      i_overflow = 1'b1;
      i_mantissa = 16'hFFFF;
      i_exponent = 8'hFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_ready", o_ready, 1'b1);
      chk("rst_mant", o_mantissa, 16'h0);
      chk("rst_exp", o_exponent, 8'h0);
      chk("rst_flags", {o_zero, o_underflow, o_exp_sat}, 3'b000);
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_rst   = 1'b0;
      @(negedge clk);
      chk("post_rst_valid", o_valid, 1'b0);
      @(posedge clk);
      #1;

      for (int k = 0; k < 10; k++) run_vec(vecs[k]);

      // Backpressure: 5 back-to-back beats, then a 3-cycle downstream stall
      base    = out_cnt;
      i_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         i_valid    = 1'b1;
         i_overflow = 1'b0;
         i_mantissa = 16'h1000 >> k;
         i_exponent = 8'(30 + k);
         @(negedge clk);
         chk("bp_ready_stream", o_ready, 1'b1);
         @(posedge clk);
         #1;
      end
      i_valid = 1'b0;
      i_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_ready_full", o_ready, 1'b0);
         chk("bp_valid_hold", o_valid, 1'b1);
         if (k == 0) hold_val = {o_mantissa, o_exponent, o_zero, o_underflow, o_exp_sat};
         else chk("bp_hold_value", {o_mantissa, o_exponent, o_zero, o_underflow, o_exp_sat}, hold_val);
         @(posedge clk);
         #1;
      end
      drain("bp_drain");
      chk("bp_count", out_cnt - base, 5);

      // Reset with two beats in flight
      base = out_cnt;
      i_ready = 1'b1;
      i_valid = 1'b1; i_overflow = 1'b0; i_mantissa = 16'h00F0; i_exponent = 8'd40;
      @(posedge clk);
      #1;
      i_mantissa = 16'h0003; i_exponent = 8'd50;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      i_rst   = 1'b1;
      @(posedge clk);
      #1;
      i_rst = 1'b0;
      @(negedge clk);
      chk("rstmid_valid", o_valid, 1'b0);
      chk("rstmid_ready", o_ready, 1'b1);
      chk("rstmid_no_out", out_cnt - base, 0);
      @(posedge clk);
      #1;
      run_vec('{"rstmid_new", 1'b0, 16'h4000, 8'd9, '{16'h8000, 8'd8, 1'b0, 1'b0, 1'b0}});
      chk("rstmid_count", out_cnt - base, 1);

      // Randomized traffic against the scoreboard
      for (int k = 0; k < 500; k++) begin
         i_ready    = ($urandom % 4) != 0;
         i_valid    = ($urandom % 3) != 0;
         i_overflow = ($urandom % 4) == 0;
         i_mantissa = 16'($urandom) >> $urandom_range(0, 16);
         case ($urandom % 4)
            0:       i_exponent = 8'($urandom_range(0, 16));
            1:       i_exponent = 8'($urandom_range(250, 255));
            default: i_exponent = 8'($urandom);
         endcase
         @(posedge clk);
         #1;
      end
      drain("rand_drain");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/norm_pipe.md
NORM_PIPE -- requirements
Module: norm_pipe

Interface
REQ-001 Parameter SIZE_DATA, default 16, mantissa width in bits (legal range 4..64).
REQ-002 Parameter SIZE_EXP, default 8, exponent width in bits.
REQ-003 Parameter SIZE_LOPD, default $clog2(SIZE_DATA), width of the internal leading-one position.
REQ-004 i_clk  in  1  clock; the only clock; all flops on its rising edge.
REQ-005 i_rst  in  1  reset; synchronous, active-high.
REQ-006 i_valid  in  1  input beat valid.
REQ-007 o_ready  out  1  block can accept an input beat.
REQ-008 i_overflow  in  1  carry out of the preceding adder.
REQ-009 i_mantissa  in  SIZE_DATA  raw adder mantissa.
REQ-010 i_exponent  in  SIZE_EXP  biased exponent before normalisation.
REQ-011 o_valid  out  1  output beat valid.
REQ-012 i_ready  in  1  downstream accepts the output beat.
REQ-013 o_mantissa  out  SIZE_DATA  normalised mantissa, MSB = 1 unless zero.
REQ-014 o_exponent  out  SIZE_EXP  adjusted exponent.
REQ-015 o_zero  out  1  result is zero.
REQ-016 o_underflow  out  1  left shift would take the exponent below 1; result flushed to zero.
REQ-017 o_exp_sat  out  1  exponent increment saturated at all-ones.

Function
REQ-018 Input transfer occurs when i_valid && o_ready; output transfer occurs when o_valid && i_ready.
REQ-019 Two register stages. S1 captures the inputs, the leading-zero count lz (0..SIZE_DATA-1) and the zero detect. S2 performs the shift, the exponent adjust and the flags.
REQ-020 Latency is 2 cycles from input transfer to o_valid; throughput is one beat per cycle with no bubbles while i_ready=1.
REQ-021 A stage loads when it is empty or its content moves on in the same cycle. o_ready = ~S1_valid | S2 advance. There is no combinational path from i_valid to o_valid.
REQ-022 While o_valid=1 and i_ready=0, all outputs hold stable.
REQ-023 Priority is zero, then overflow, then normal.
- Zero case: i_overflow=0 and i_mantissa=0. Output mantissa 0, exponent 0, o_zero=1.
REQ-024 Overflow case: mantissa = {1'b1, i_mantissa[SIZE_DATA-1:1]}, exponent = i_exponent+1.
- If i_exponent+1 overflows, or i_exponent is already all-ones, the exponent saturates to all-ones and o_exp_sat=1.
REQ-025 Normal case with MSB=1: mantissa and exponent pass through unchanged.
REQ-026 Normal case with MSB=0: mantissa = i_mantissa << lz.
- If lz < i_exponent: exponent = i_exponent - lz.
- Otherwise: mantissa 0, exponent 0, o_zero=1, o_underflow=1.
REQ-027 Flags are valid only with o_valid and are 0 on all other cycles.

Reset
REQ-028 With i_rst=1 at a clock edge, both stage valids clear. After that edge: o_valid=0, o_ready=1, and o_mantissa, o_exponent and all flags are 0.
REQ-029 Reset mid-operation discards every in-flight beat with no output transfer. o_ready=1 on the first cycle after reset deasserts.
REQ-030 Inputs presented while i_rst=1 are ignored.

Configuration
REQ-031 The macro NORM_PIPE_STICKY_EN controls how the bit shifted out on overflow is handled.
- Defined: in the overflow case, o_mantissa[0] = i_mantissa[1] | i_mantissa[0], so the shifted-out bit is kept as sticky.
- Not defined: the shifted-out bit is discarded, per REQ-024.
REQ-032 The macro has no effect on latency, the handshake or the other cases.

Verification (SIZE_DATA=16, SIZE_EXP=8)
REQ-033 Normal shift. Input mant 16'h0100, exp 20, ovf 0 -> 2 cycles later: mant 16'h8000, exp 13, all flags 0.
REQ-034 Overflow. Input mant 16'h0005, exp 10, ovf 1 -> exp 11.
- mant 16'h8002 without NORM_PIPE_STICKY_EN.
- mant 16'h8003 with NORM_PIPE_STICKY_EN.
REQ-035 Boundaries, each checked separately.
- mant 16'h0001, exp 5 -> mant 0, exp 0, o_zero=1, o_underflow=1.
- mant 0, ovf 0 -> o_zero=1, o_underflow=0.
- ovf 1, exp 8'hFE -> exp 8'hFF, o_exp_sat=0.
- ovf 1, exp 8'hFF -> exp 8'hFF, o_exp_sat=1.
REQ-036 Backpressure. Stream 5 back-to-back beats, then hold i_ready=0 for 3 cycles.
- o_ready falls once both stages are full.
- Outputs are stable during the hold.
- All 5 beats arrive in order with none lost or duplicated.
REQ-037 Reset mid-stream. Assert i_rst for 1 cycle with 2 beats in flight.
- No output transfer occurs for those beats.
- o_valid=0 and o_ready=1 next cycle.
- A new beat then emerges exactly 2 cycles after its input transfer.
